// File: rtl/uart_rx_core.sv
// Purpose: UART receiver that turns an oversampled serial line into DATA_W-bit words, with optional even/odd parity.
// Latency: DATA_VALID rises (1+DATA_W+PAR_EN)*OVS + OVS/2 + 4 cycles after the start edge on RX_IN.
// Backpressure: none. The status pulses last one cycle and are not held, so the consumer must take them when they occur.
module uart_rx_core #(
  parameter int OVS    = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [DATA_W-1:0] P_DATA,
  output logic              DATA_VALID,
  output logic              PAR_ERR,
  output logic              STP_ERR,
  output logic              Busy
);

  localparam int EW = $clog2(OVS);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [EW-1:0] E_S0   = EW'(OVS/2 - 1);
  localparam logic [EW-1:0] E_S1   = EW'(OVS/2);
  localparam logic [EW-1:0] E_DEC  = EW'(OVS/2 + 1);
  localparam logic [EW-1:0] E_LAST = EW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state, state_nxt;
  logic                rst_meta, rst_n_s;
  logic                rx_m, rx_s;
  logic [EW-1:0]       edge_cnt;
  logic [BW-1:0]       bit_cnt;
  logic                samp0, samp1;
  logic [DATA_W-1:0]   shreg;
  logic                par_en_l, par_typ_l, perr_flag;
  logic                bit_val, dec, wrap;
  logic                dv_nxt, pe_nxt, se_nxt;

  // Reset asserts immediately and is released only on a clock edge, so no flop leaves reset mid-cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rst_meta <= 1'b0;
      rst_n_s  <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n_s  <= rst_meta;
    end
  end

  // Two-flop synchroniser for the asynchronous line. It resets to the idle level (high) so no false start is seen.
  always_ff @(posedge CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX_IN;
      rx_s <= rx_m;
    end
  end

  // The bit value is the 2-of-3 majority of the three samples around the bit centre.
  // The third sample is the live rx_s, taken in the cycle the decision is made.
  assign bit_val = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign dec     = (edge_cnt == E_DEC);
  assign wrap    = (edge_cnt == E_LAST);
  assign Busy    = (state != S_IDLE);

  // State register.
  always_ff @(posedge CLK or negedge rst_n_s) begin
    if (!rst_n_s) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and the stop-bit evaluation that drives the output pulses.
  always_comb begin
    state_nxt = state;
    dv_nxt    = 1'b0;
    pe_nxt    = 1'b0;
    se_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (dec && bit_val) state_nxt = S_IDLE;
        else if (wrap)      state_nxt = S_DATA;
      end
      S_DATA: begin
        if (wrap && (bit_cnt == B_LAST)) state_nxt = par_en_l ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (wrap) state_nxt = S_STOP;
      end
      S_STOP: begin
        // The FSM leaves at the decision point rather than at bit end.
        // This keeps the second half of the stop bit open for detecting the next start edge.
        if (dec) begin
          state_nxt = S_IDLE;
          dv_nxt    = bit_val & ~perr_flag;
          pe_nxt    = perr_flag;
          se_nxt    = ~bit_val;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit-timing counters: edge_cnt tracks position within a bit, bit_cnt counts data bits.
  always_ff @(posedge CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == S_IDLE || state_nxt == S_IDLE || wrap) edge_cnt <= '0;
      else                                                edge_cnt <= edge_cnt + 1'b1;
      if (state == S_IDLE)                 bit_cnt <= '0;
      else if (state == S_DATA && wrap)    bit_cnt <= (bit_cnt == B_LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  // Datapath: centre samples, LSB-first shift register, and per-frame parity settings and parity result.
  always_ff @(posedge CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      samp0     <= 1'b1;
      samp1     <= 1'b1;
      shreg     <= '0;
      par_en_l  <= 1'b0;
      par_typ_l <= 1'b0;
      perr_flag <= 1'b0;
    end else begin
      if (state != S_IDLE && edge_cnt == E_S0) samp0 <= rx_s;
      if (state != S_IDLE && edge_cnt == E_S1) samp1 <= rx_s;
      if (state == S_IDLE && !rx_s) begin
        par_en_l  <= PAR_EN;
        par_typ_l <= PAR_TYP;
        perr_flag <= 1'b0;
      end
      if (state == S_DATA && dec) shreg <= {bit_val, shreg[DATA_W-1:1]};
      // Expected parity bit is XOR(data) for even parity and its inverse for odd parity.
      if (state == S_PARITY && dec) perr_flag <= bit_val ^ (^shreg) ^ par_typ_l;
    end
  end

  // Registered outputs: each pulse lasts one cycle, and P_DATA updates only on an error-free frame.
  always_ff @(posedge CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= dv_nxt;
      PAR_ERR    <= pe_nxt;
      STP_ERR    <= se_nxt;
      if (dv_nxt) P_DATA <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Purpose: directed testbench for uart_rx_core, with hand-computed frames and expected results.
// Latency: the pulse monitor samples outputs on the falling clock edge.
// Backpressure: not applicable.
module tb_uart_rx_core;
  localparam int OVS = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR, Busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;
  int dv_cyc = -1;
  logic [7:0] dv_data [0:3];

  uart_rx_core #(.OVS(OVS), .DATA_W(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Count every output pulse, measured in cycles, and record the data delivered with each one.
  always @(negedge CLK) begin
    if (DATA_VALID) begin
      if (dv_cnt < 4) dv_data[dv_cnt] = P_DATA;
      if (dv_cnt == 0) dv_cyc = cyc;
      dv_cnt = dv_cnt + 1;
    end
    if (PAR_ERR) pe_cnt = pe_cnt + 1;
    if (STP_ERR) se_cnt = se_cnt + 1;
  end

  task automatic clear_counts();
    @(posedge CLK);
    #1;
    dv_cnt = 0; pe_cnt = 0; se_cnt = 0; dv_cyc = -1;
  endtask

  // Drive one frame, one level per falling edge. The line stays at the stop level afterwards.
  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                            input logic stop_bit, input logic spike);
    logic [10:0] bits;
    int nb;
    nb = has_par ? 11 : 10;
    bits = has_par ? {stop_bit, par_bit, d, 1'b0} : {1'b0, stop_bit, d, 1'b0};
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < OVS; j++) begin
        @(negedge CLK);
        if (i == 0 && j == 0) start_cyc = cyc;
        RX_IN = (spike && i >= 1 && i <= 8 && j == OVS/2) ? 1'b0 : bits[i];
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_busy_in_reset got=%b exp=0", Busy); end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (6) @(negedge CLK);
    total++; if (P_DATA !== 8'h00) begin bad++; $display("FAIL rst_pdata got=%h exp=00", P_DATA); end
    total++; if (DATA_VALID !== 1'b0) begin bad++; $display("FAIL rst_dv got=%b exp=0", DATA_VALID); end
    total++; if (PAR_ERR !== 1'b0) begin bad++; $display("FAIL rst_parerr got=%b exp=0", PAR_ERR); end
    total++; if (STP_ERR !== 1'b0) begin bad++; $display("FAIL rst_stperr got=%b exp=0", STP_ERR); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", Busy); end
  endtask

  task automatic test_plain();
    int lat;
    PAR_EN = 1'b0;
    clear_counts();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2*OVS);
    total++; if (dv_cnt !== 1) begin bad++; $display("FAIL plain_dv_count got=%0d exp=1", dv_cnt); end
    total++; if (P_DATA !== 8'hA5) begin bad++; $display("FAIL plain_data got=%h exp=a5", P_DATA); end
    total++; if (pe_cnt + se_cnt !== 0) begin bad++; $display("FAIL plain_err_pulses got=%0d exp=0", pe_cnt + se_cnt); end
    // The +1 accounts for the half cycle between the falling-edge drive and the first rising edge that samples it.
    lat = dv_cyc - start_cyc;
    total++; if (lat !== 9*OVS + OVS/2 + 4 + 1) begin bad++; $display("FAIL plain_latency got=%0d exp=%0d", lat, 9*OVS + OVS/2 + 5); end
  endtask

  task automatic test_parity_even();
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    clear_counts();
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2*OVS);
    total++; if (dv_cnt !== 1) begin bad++; $display("FAIL even_ok_dv got=%0d exp=1", dv_cnt); end
    total++; if (P_DATA !== 8'h03) begin bad++; $display("FAIL even_ok_data got=%h exp=03", P_DATA); end
    total++; if (pe_cnt !== 0) begin bad++; $display("FAIL even_ok_parerr got=%0d exp=0", pe_cnt); end
    clear_counts();
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2*OVS);
    total++; if (dv_cnt !== 0) begin bad++; $display("FAIL even_bad_dv got=%0d exp=0", dv_cnt); end
    total++; if (pe_cnt !== 1) begin bad++; $display("FAIL even_bad_parerr got=%0d exp=1", pe_cnt); end
    total++; if (se_cnt !== 0) begin bad++; $display("FAIL even_bad_stperr got=%0d exp=0", se_cnt); end
    total++; if (P_DATA !== 8'h03) begin bad++; $display("FAIL even_bad_hold got=%h exp=03", P_DATA); end
  endtask

  task automatic test_odd_stop_err();
    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    clear_counts();
    // XOR(0x07)=1, so the correct odd parity bit is 0. Only the stop bit is bad.
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3*OVS);
    total++; if (se_cnt !== 1) begin bad++; $display("FAIL odd_stp_stperr got=%0d exp=1", se_cnt); end
    total++; if (dv_cnt !== 0) begin bad++; $display("FAIL odd_stp_dv got=%0d exp=0", dv_cnt); end
    total++; if (pe_cnt !== 0) begin bad++; $display("FAIL odd_stp_parerr got=%0d exp=0", pe_cnt); end
    total++; if (P_DATA !== 8'h03) begin bad++; $display("FAIL odd_stp_hold got=%h exp=03", P_DATA); end
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
  endtask

  task automatic test_glitch();
    clear_counts();
    @(negedge CLK); RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    @(negedge CLK);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_mid got=%b exp=1", Busy); end
    repeat (10) @(negedge CLK);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b exp=0", Busy); end
    total++; if (dv_cnt + pe_cnt + se_cnt !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", dv_cnt + pe_cnt + se_cnt); end
  endtask

  task automatic test_spike();
    clear_counts();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2*OVS);
    total++; if (dv_cnt !== 1) begin bad++; $display("FAIL spike_dv got=%0d exp=1", dv_cnt); end
    total++; if (P_DATA !== 8'hFF) begin bad++; $display("FAIL spike_data got=%h exp=ff", P_DATA); end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2*OVS);
    total++; if (dv_cnt !== 2) begin bad++; $display("FAIL b2b_dv_count got=%0d exp=2", dv_cnt); end
    total++; if (dv_data[0] !== 8'h55) begin bad++; $display("FAIL b2b_first got=%h exp=55", dv_data[0]); end
    total++; if (dv_data[1] !== 8'hAA) begin bad++; $display("FAIL b2b_second got=%h exp=aa", dv_data[1]); end
    total++; if (se_cnt + pe_cnt !== 0) begin bad++; $display("FAIL b2b_err got=%0d exp=0", se_cnt + pe_cnt); end
  endtask

  task automatic test_break();
    clear_counts();
    // Two frame-times of low line. Each frame-time ends in a stop error, and the line is high again before the third one starts.
    @(negedge CLK); RX_IN = 1'b0;
    repeat (20*OVS - 1) @(negedge CLK);
    idle(3*OVS);
    total++; if (se_cnt !== 2) begin bad++; $display("FAIL break_stperr got=%0d exp=2", se_cnt); end
    total++; if (dv_cnt !== 0) begin bad++; $display("FAIL break_dv got=%0d exp=0", dv_cnt); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL break_busy got=%b exp=0", Busy); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    d = 8'h3C;
    clear_counts();
    // Drive the start bit, data bits 0..3, and half of bit 4.
    for (int i = 0; i < 5*OVS + OVS/2; i++) begin
      @(negedge CLK);
      RX_IN = (i < OVS) ? 1'b0 : d[(i - OVS) / OVS];
    end
    RST = 1'b0;
    @(negedge CLK);
    RX_IN = 1'b1;
    total++; if (P_DATA !== 8'h00) begin bad++; $display("FAIL mrst_pdata got=%h exp=00", P_DATA); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%b exp=0", Busy); end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(OVS);
    total++; if (dv_cnt + pe_cnt + se_cnt !== 0) begin bad++; $display("FAIL mrst_pulses got=%0d exp=0", dv_cnt + pe_cnt + se_cnt); end
    clear_counts();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2*OVS);
    total++; if (dv_cnt !== 1) begin bad++; $display("FAIL mrst_next_dv got=%0d exp=1", dv_cnt); end
    total++; if (P_DATA !== 8'h3C) begin bad++; $display("FAIL mrst_next_data got=%h exp=3c", P_DATA); end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_parity_even();
    test_odd_stop_err();
    test_glitch();
    test_spike();
    test_back_to_back();
    test_break();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
